pipelined_decoder: RTL

PIPELINED_DECODER -- requirements
Module: pipelined_decoder

---
 rtl/pipelined_decoder.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/pipelined_decoder.sv
// pipelined_decoder
//   RV32 instruction decoder sitting between fetch and execute. Each accepted
//   instruction is decoded as it is written into a 2-entry FIFO made of the
//   output register plus a skid register. The output is available one cycle
//   after the input transfer. in_ready is driven straight from the skid
//   register's valid bit, so there is no combinational path from out_ready
//   to in_ready.
//
// Parameters
//   XLEN            width of the immediate and PC datapath (32 or 64)
//
// Ports
//   clk             clock, all state updates on the rising edge
//   reset           synchronous, active-high; clears both entries and all outputs
//   flush           squash: drops both held entries and any input beat this cycle
//   in_valid        fetch presents in_instruction / in_pc
//   in_ready        decoder can take a beat (skid register empty)
//   in_instruction  raw 32-bit instruction word
//   in_pc           PC of in_instruction
//   out_valid       decoded entry available
//   out_ready       execute consumes the entry
//   out_opcode, out_funct3, out_funct7, out_rs1, out_rs2, out_rd
//                   decoded fields, zero where the format does not use them
//   out_imm         sign-extended immediate
//   out_pc          PC travelling with the instruction
//   out_illegal     illegal-instruction flag
//
// Configuration
//   DECODER_ILLEGAL_CHECK_EN  when defined, out_illegal is raised for
//   unrecognised opcodes, for inst[1:0] != 2'b11, and for R-type with an
//   unsupported funct7. When undefined, out_illegal is constant 0.

module pipelined_decoder #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instruction,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } entry_t;

  entry_t     dec;
  entry_t     out_q;
  entry_t     skid_q;
  logic       out_valid_q;
  logic       skid_valid_q;
  logic [31:0] imm32;

  // Combinational decode of the incoming word. The immediate is first built
  // and sign-extended to 32 bits, then widened to XLEN from bit 31.
  always_comb begin
    dec        = '0;
    imm32      = '0;
    dec.opcode = in_instruction[6:0];
    dec.pc     = in_pc;
    case (in_instruction[6:0])
      OP_LUI, OP_AUIPC: begin
        dec.rd = in_instruction[11:7];
        imm32  = {in_instruction[31:12], 12'b0};
      end
      OP_JAL: begin
        dec.rd = in_instruction[11:7];
        imm32  = {{11{in_instruction[31]}}, in_instruction[31], in_instruction[19:12],
                  in_instruction[20], in_instruction[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD, OP_ITYPE, OP_FENCE, OP_SYSTEM: begin
        dec.rd     = in_instruction[11:7];
        dec.funct3 = in_instruction[14:12];
        dec.rs1    = in_instruction[19:15];
        imm32      = {{20{in_instruction[31]}}, in_instruction[31:20]};
      end
      OP_BRANCH: begin
        dec.funct3 = in_instruction[14:12];
        dec.rs1    = in_instruction[19:15];
        dec.rs2    = in_instruction[24:20];
        imm32      = {{19{in_instruction[31]}}, in_instruction[31], in_instruction[7],
                      in_instruction[30:25], in_instruction[11:8], 1'b0};
      end
      OP_STORE: begin
        dec.funct3 = in_instruction[14:12];
        dec.rs1    = in_instruction[19:15];
        dec.rs2    = in_instruction[24:20];
        imm32      = {{20{in_instruction[31]}}, in_instruction[31:25], in_instruction[11:7]};
      end
      OP_RTYPE: begin
        dec.rd     = in_instruction[11:7];
        dec.funct3 = in_instruction[14:12];
        dec.rs1    = in_instruction[19:15];
        dec.rs2    = in_instruction[24:20];
        dec.funct7 = in_instruction[31:25];
`ifdef DECODER_ILLEGAL_CHECK_EN
        dec.illegal = (in_instruction[31:25] != 7'b0000000) &&
                      (in_instruction[31:25] != 7'b0100000);
`endif
      end
      default: begin
`ifdef DECODER_ILLEGAL_CHECK_EN
        dec.illegal = 1'b1;
`endif
      end
    endcase
`ifdef DECODER_ILLEGAL_CHECK_EN
    // Compressed encodings (low bits != 11) are not supported here.
    if (in_instruction[1:0] != 2'b11) begin
      dec.illegal = 1'b1;
    end
`endif
    dec.imm        = {XLEN{imm32[31]}};
    dec.imm[31:0]  = imm32;
  end

  // Two-entry FIFO. When the output slot frees up (empty or being consumed)
  // it is refilled from the skid register first, otherwise straight from the
  // input. A stalled output sends the next beat into the skid register.
  // Skid full implies in_ready low, so no input beat can arrive that would
  // need to bypass the skid entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (in_valid) begin
        out_q       <= dec;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (in_valid && !skid_valid_q) begin
      skid_q       <= dec;
      skid_valid_q <= 1'b1;
    end
  end

  assign in_ready    = ~skid_valid_q;
  assign out_valid   = out_valid_q;
  assign out_opcode  = out_q.opcode;
  assign out_funct3  = out_q.funct3;
  assign out_funct7  = out_q.funct7;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_rd      = out_q.rd;
  assign out_imm     = out_q.imm;
  assign out_pc      = out_q.pc;
  assign out_illegal = out_q.illegal;

endmodule
